// File: rtl/serial_adder_seq.sv
// Bit-serial adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock, LSB first,
// through a registered carry; result, carry-out and signed overflow returned behind start/busy/done.
module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder_seq: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last_step;
  logic [DIGIT-1:0] step_sum;
  logic [DIGIT:0]   c_vec;
  logic [WIDTH-1:0] step_ext, sum_nxt;

  // Handshake: start is taken only while ready (IDLE or DONE); busy is high for the N RUN
  // cycles, done pulses for one cycle with sum/cout/overflow valid and held until the next take.
  assign accept    = start && (state == IDLE || state == DONE);
  assign last_step = (state == RUN) && (cnt_q == LAST);

  // One DIGIT-wide ripple slice; c_vec[DIGIT-1] is the carry into the slice MSB.
  always_comb begin
    c_vec    = '0;
    step_sum = '0;
    c_vec[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      step_sum[i] = a_q[i] ^ b_q[i] ^ c_vec[i];
      c_vec[i+1]  = (a_q[i] & b_q[i]) | (c_vec[i] & (a_q[i] ^ b_q[i]));
    end
  end

  assign step_ext = WIDTH'(step_sum);
  assign sum_nxt  = (sum_q >> DIGIT) | (step_ext << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_q == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= cin ^ sub;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      sum_q   <= sum_nxt;
      carry_q <= c_vec[DIGIT];
      if (last_step) begin
        cout_q <= c_vec[DIGIT];
        ovf_q  <= c_vec[DIGIT] ^ c_vec[DIGIT-1];
      end else begin
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: four configurations (8/1, 8/2, 16/4, 32/8) side by side,
// directed corner cases plus random operations against a plain-arithmetic reference model.
module tb_serial_adder_seq;

  localparam int NCFG = 4;
  localparam int W_TAB [NCFG] = '{8, 8, 16, 32};
  localparam int D_TAB [NCFG] = '{1, 2, 4, 8};

  logic        clk, rst_n;
  logic        start_v [NCFG];
  logic        sub_v   [NCFG];
  logic        cin_v   [NCFG];
  logic [31:0] a_v     [NCFG];
  logic [31:0] b_v     [NCFG];
  logic [31:0] sum_v   [NCFG];
  logic        busy_v  [NCFG];
  logic        done_v  [NCFG];
  logic        cout_v  [NCFG];
  logic        ovf_v   [NCFG];

  int n_vec  = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int W = W_TAB[g];
    localparam int D = D_TAB[g];
    logic [W-1:0] s;
    serial_adder_seq #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_v[g]),
      .sub      (sub_v[g]),
      .a        (a_v[g][W-1:0]),
      .b        (b_v[g][W-1:0]),
      .cin      (cin_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .sum      (s),
      .cout     (cout_v[g]),
      .overflow (ovf_v[g])
    );
    assign sum_v[g] = 32'(s);
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true unsigned and signed results of a+b+cin or a-b-cin.
  function automatic void ref_model(input int w, input logic s, input logic [31:0] a,
                                    input logic [31:0] b, input logic ci,
                                    output logic [31:0] es, output logic ec, output logic eo);
    longint m, ua, ub, sa, sb, ur, sr;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = ((ua >> (w - 1)) & 1) != 0 ? ua - (m + 1) : ua;
    sb = ((ub >> (w - 1)) & 1) != 0 ? ub - (m + 1) : ub;
    if (!s) begin
      ur = ua + ub + longint'(ci);
      sr = sa + sb + longint'(ci);
      ec = (ur > m);
    end else begin
      ur = ua - ub - longint'(ci);
      sr = sa - sb - longint'(ci);
      ec = (ur >= 0);
    end
    es = 32'(ur & m);
    eo = (sr > (m >> 1)) || (sr < -((m >> 1) + 1));
  endfunction

  // driver: one full operation on config c, checking latency and result
  task automatic run_op(input int c, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input string tag);
    int w, n, cyc;
    logic [31:0] es;
    logic ec, eo;
    w = W_TAB[c];
    n = w / D_TAB[c];
    ref_model(w, s, a, b, ci, es, ec, eo);
    @(posedge clk); #1;
    sub_v[c] = s; a_v[c] = a; b_v[c] = b; cin_v[c] = ci; start_v[c] = 1'b1;
    @(posedge clk); #1;
    start_v[c] = 1'b0;
    a_v[c] = $urandom; b_v[c] = $urandom;
    sub_v[c] = 1'($urandom_range(0, 1)); cin_v[c] = 1'($urandom_range(0, 1));
    n_vec++;
    if (busy_v[c] !== 1'b1) begin
      n_fail++; $display("FAIL %s busy: got %b want 1", tag, busy_v[c]);
    end
    cyc = 0;
    while (cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (done_v[c] === 1'b1) break;
    end
    n_vec++;
    if (done_v[c] !== 1'b1 || cyc != n) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles (done=%b) want %0d", tag, cyc, done_v[c], n);
    end
    n_vec++;
    if (sum_v[c] !== es) begin
      n_fail++; $display("FAIL %s sum: got %h want %h", tag, sum_v[c], es);
    end
    n_vec++;
    if (cout_v[c] !== ec) begin
      n_fail++; $display("FAIL %s cout: got %b want %b", tag, cout_v[c], ec);
    end
    n_vec++;
    if (ovf_v[c] !== eo) begin
      n_fail++; $display("FAIL %s ovf: got %b want %b", tag, ovf_v[c], eo);
    end
    n_vec++;
    if (busy_v[c] !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy_v[c]);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < NCFG; c++) begin
      start_v[c] = 1'b0; sub_v[c] = 1'b0; cin_v[c] = 1'b0;
      a_v[c] = $urandom; b_v[c] = $urandom;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < NCFG; c++) begin
      n_vec++;
      if ({busy_v[c], done_v[c], cout_v[c], ovf_v[c], sum_v[c]} !== 36'h0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
                 c, busy_v[c], done_v[c], cout_v[c], ovf_v[c], sum_v[c]);
      end
    end
  endtask

  task automatic test_directed();
    run_op(0, 1'b0, 32'd37,   32'd21,    1'b0, "add_37_21");
    run_op(0, 1'b0, 32'hFF,   32'h01,    1'b0, "add_ff_01");
    run_op(0, 1'b0, 32'h7F,   32'h01,    1'b0, "add_7f_01");
    run_op(0, 1'b1, 32'd5,    32'd7,     1'b0, "sub_5_7");
    run_op(0, 1'b1, 32'h80,   32'h01,    1'b0, "sub_80_01");
    run_op(0, 1'b1, 32'd10,   32'd3,     1'b1, "sub_10_3_b");
    run_op(2, 1'b0, 32'h1234, 32'h0FFF,  1'b0, "add16_1234");
    run_op(3, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, "add32_wrap");
    run_op(1, 1'b1, 32'h00,   32'h00,    1'b1, "sub8_0_0_b");
  endtask

  task automatic test_busy_ignored();
    int cyc, extra;
    @(posedge clk); #1;
    sub_v[2] = 1'b0; cin_v[2] = 1'b0; a_v[2] = 32'h1234; b_v[2] = 32'h0FFF; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    @(posedge clk); #1;
    a_v[2] = 32'hFFFF; b_v[2] = 32'hFFFF; sub_v[2] = 1'b1; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    cyc = 2;
    while (cyc < 40 && done_v[2] !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (done_v[2] !== 1'b1 || cyc != 4) begin
      n_fail++; $display("FAIL busy_ign latency: got %0d want 4", cyc);
    end
    n_vec++;
    if (sum_v[2] !== 32'h2233) begin
      n_fail++; $display("FAIL busy_ign sum: got %h want 2233", sum_v[2]);
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_v[2] === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_fail++; $display("FAIL busy_ign queued: got %0d extra done pulses want 0", extra);
    end
    n_vec++;
    if (sum_v[2] !== 32'h2233) begin
      n_fail++; $display("FAIL busy_ign hold: got %h want 2233", sum_v[2]);
    end
  endtask

  // scoreboard: start held high, each DONE-cycle edge captures the next operands
  task automatic test_back_to_back();
    int edges, ops, got, n;
    logic [31:0] ra, rb, es;
    logic rs, rc, ec, eo;
    logic [33:0] e;
    n = W_TAB[2] / D_TAB[2];
    exp_q.delete();
    @(posedge clk); #1;
    ra = 32'($urandom_range(0, 65535)); rb = 32'($urandom_range(0, 65535));
    rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
    ref_model(16, rs, ra, rb, rc, es, ec, eo);
    exp_q.push_back({ec, eo, es});
    a_v[2] = ra; b_v[2] = rb; sub_v[2] = rs; cin_v[2] = rc; start_v[2] = 1'b1;
    @(posedge clk); #1;
    ops = 1; got = 0; edges = 0;
    while (edges < 40 && got < 4) begin
      @(posedge clk); #1;
      edges++;
      if (done_v[2] === 1'b1) begin
        n_vec++;
        if (edges != ((got == 0) ? n : n + 1)) begin
          n_fail++; $display("FAIL b2b interval%0d: got %0d want %0d", got, edges, (got == 0) ? n : n + 1);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({cout_v[2], ovf_v[2], sum_v[2]} !== e) begin
          n_fail++; $display("FAIL b2b result%0d: got %b %b %h want %b %b %h",
                             got, cout_v[2], ovf_v[2], sum_v[2], e[33], e[32], e[31:0]);
        end
        got++;
        if (ops < 4) begin
          ra = 32'($urandom_range(0, 65535)); rb = 32'($urandom_range(0, 65535));
          rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
          ref_model(16, rs, ra, rb, rc, es, ec, eo);
          exp_q.push_back({ec, eo, es});
          a_v[2] = ra; b_v[2] = rb; sub_v[2] = rs; cin_v[2] = rc;
          ops++;
        end else begin
          start_v[2] = 1'b0;
        end
        edges = 0;
      end
    end
    start_v[2] = 1'b0;
    n_vec++;
    if (got != 4) begin
      n_fail++; $display("FAIL b2b count: got %0d done pulses want 4", got);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(posedge clk); #1;
    sub_v[0] = 1'b0; cin_v[0] = 1'b1; a_v[0] = 32'hFF; b_v[0] = 32'h00; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_v[0], done_v[0], cout_v[0], ovf_v[0], sum_v[0]} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b cout=%b ovf=%b sum=%h want all 0",
               busy_v[0], done_v[0], cout_v[0], ovf_v[0], sum_v[0]);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_v[0] === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL reset_mid stray_done: got %0d pulses want 0", pulses);
    end
    run_op(0, 1'b0, 32'd1, 32'd2, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int c = 0; c < NCFG; c++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(c, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
               $sformatf("rand_cfg%0d_%0d", c, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
